// File: rtl/gsim_shreg_seq_if.sv
// Handshake/control bundle between the GSIM sequencer and its I/O, arithmetic unit and shift register.
// master drives the sequencer's inputs; slave is the sequencer itself.
interface gsim_shreg_seq_if #(
  parameter int ITER_W = 8
);
  logic              start;
  logic [ITER_W-1:0] iter_num;
  logic              in_valid;
  logic              in_ready;
  logic              issue_valid;
  logic              issue_ready;
  logic              upd_valid;
  logic [2:0]        sh_ctrl;
  logic              sh_ien;
  logic              in_sel;
  logic [3:0]        row_idx;
  logic [ITER_W-1:0] iter_cnt;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, iter_num, in_valid, issue_ready, upd_valid, out_ready,
    input  in_ready, issue_valid, sh_ctrl, sh_ien, in_sel, row_idx, iter_cnt,
           out_valid, busy, done, err
  );

  modport slave (
    input  start, iter_num, in_valid, issue_ready, upd_valid, out_ready,
    output in_ready, issue_valid, sh_ctrl, sh_ien, in_sel, row_idx, iter_cnt,
           out_valid, busy, done, err
  );
endinterface

// File: rtl/gsim_shreg_seq.sv
// GSIM shift-register sequencer: load 16 words, N iterations of 16 issue/write-back rows, drain 16 results.
// Shift controls are combinational so each shift lands on the accepting edge; all handshakes stall freely.
module gsim_shreg_seq #(
  parameter int ITER_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  gsim_shreg_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ITER_W-1:0] iter_q, iter_q_nxt;
  logic [ITER_W-1:0] iter_cnt, iter_cnt_nxt;
  logic              err_q, err_nxt;
  logic [ITER_W:0]   iter_inc;
  logic [2:0]        sh_ctrl;
  logic              sh_ien;
  logic              in_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      iter_q   <= ITER_W'(1);
      iter_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      iter_q   <= iter_q_nxt;
      iter_cnt <= iter_cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    iter_q_nxt   = iter_q;
    iter_cnt_nxt = iter_cnt;
    err_nxt      = err_q;
    sh_ctrl      = 3'b000;
    sh_ien       = 1'b0;
    in_sel       = 1'b0;
    iter_inc     = {1'b0, iter_cnt} + 1'b1;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          iter_q_nxt   = (bus.iter_num == '0) ? ITER_W'(1) : bus.iter_num;
          cnt_nxt      = '0;
          iter_cnt_nxt = '0;
          err_nxt      = 1'b0;
          state_nxt    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          sh_ctrl = 3'b001;
          sh_ien  = 1'b1;
          if (cnt == 4'd15) begin
            cnt_nxt   = '0;
            state_nxt = S_ISSUE;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      S_ISSUE: begin
        if (bus.issue_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        in_sel = 1'b1;
        if (bus.upd_valid) begin
          sh_ctrl = 3'b001;
          sh_ien  = 1'b1;
          if (cnt == 4'd15) begin
            cnt_nxt = '0;
            if (iter_cnt != '1) iter_cnt_nxt = iter_inc[ITER_W-1:0];
            // compared one bit wider so the final increment can never alias
            state_nxt = (iter_inc == {1'b0, iter_q}) ? S_DRAIN : S_ISSUE;
          end else begin
            cnt_nxt   = cnt + 4'd1;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          // rotate: slot 0 wraps back to slot 15, so 16 shifts restore the order
          sh_ctrl = 3'b001;
          sh_ien  = 1'b0;
          if (cnt == 4'd15) begin
            cnt_nxt   = '0;
            state_nxt = S_DONE;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // a stray update is flagged even when it coincides with an accepted start
    if (bus.upd_valid && state != S_WAIT) err_nxt = 1'b1;
  end

  assign bus.sh_ctrl     = sh_ctrl;
  assign bus.sh_ien      = sh_ien;
  assign bus.in_sel      = in_sel;
  assign bus.in_ready    = (state == S_LOAD);
  assign bus.issue_valid = (state == S_ISSUE);
  assign bus.out_valid   = (state == S_DRAIN);
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);
  assign bus.row_idx     = (state == S_ISSUE || state == S_WAIT) ? cnt : 4'd0;
  assign bus.iter_cnt    = iter_cnt;
  assign bus.err         = err_q;

endmodule

// File: doc/gsim_shreg_seq.md
# gsim_shreg_seq

Sequencer for the 16-entry GSIM unknown/coefficient shift register. Drives its shift control (`ctrl`, `i_en`) and input-select mux through four phases: loading 16 input words, issuing 16 row updates per iteration to the arithmetic unit, writing each returned result back, and draining the 16 final values. It sits between the top-level I/O handshake and the arithmetic pipeline and owns all iteration and row counting.

## Interface
- `ITER_W`, 8: width of the iteration-count port and counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  pulse to begin a solve; honoured only in IDLE.
- `iter_num`  in  ITER_W  iterations to run, sampled on accepted `start`; 0 is treated as 1.
- `in_valid`  in  1  external load word valid.
- `in_ready`  out  1  load word accepted when `in_valid && in_ready`.
- `issue_valid`  out  1  row update request to the arithmetic unit.
- `issue_ready`  in  1  arithmetic unit accepts the request.
- `upd_valid`  in  1  one-cycle pulse: updated unknown present on the shift register's `IN`.
- `sh_ctrl`  out  3  shift-register control: 000 hold, 001 shift-by-1.
- `sh_ien`  out  1  shift-register `i_en`.
- `in_sel`  out  1  `IN` mux select: 0 external load data, 1 arithmetic result.
- `row_idx`  out  4  row currently issued or awaited.
- `iter_cnt`  out  ITER_W  completed iterations.
- `out_valid`  out  1  result word valid (shift-register slot 0).
- `out_ready`  in  1  downstream accepts result word.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last result is accepted.
- `err`  out  1  sticky: `upd_valid` seen outside WAIT; cleared by accepted `start`.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, DRAIN, DONE. A single 4-bit counter `cnt` serves LOAD, ISSUE/WAIT (as `row_idx`) and DRAIN.
- IDLE: `start` latches `iter_num` (0 becomes 1), clears `cnt`, `iter_cnt` and `err`, then moves to LOAD.
- LOAD: `in_ready=1`, `in_sel=0`. Each accepted word drives `sh_ctrl=001`, `sh_ien=1` in the same cycle and increments `cnt`. The 16th accept (cnt=15) clears `cnt` and moves to ISSUE. With no accept, `sh_ctrl=000`, `sh_ien=0`.
- ISSUE: `issue_valid=1`. On `issue_ready`, move to WAIT. No shift occurs.
- WAIT: `in_sel=1`. On `upd_valid`, drive `sh_ctrl=001`, `sh_ien=1`: the new x enters slot 15 and the oldest value leaves slot 0.
  - Row < 15: increment `row_idx` and go to ISSUE.
  - Row 15: wrap `row_idx` to 0 and increment `iter_cnt`. If `iter_cnt+1 == iter_num`, go to DRAIN; otherwise go to ISSUE.
- DRAIN: `out_valid=1`. On `out_ready`, drive `sh_ctrl=001`, `sh_ien=0` (rotate, slot 0 wraps to 15) and increment `cnt`. The 16th accept goes to DONE. The register ends in its pre-drain order.
- DONE: `done=1` for one cycle, then IDLE.
- At most one row is outstanding. ISSUE is never entered while WAIT is pending.
- `iter_cnt` saturates at its maximum; it cannot overflow because it stops at `iter_num`.

## Timing
- Reset value of every output: `in_ready`, `issue_valid`, `sh_ctrl`, `sh_ien`, `in_sel`, `row_idx`, `iter_cnt`, `out_valid`, `busy`, `done` and `err` are all 0.
- Reset at any point returns to IDLE on the next edge. A partially shifted register is not restored; the next solve reloads it.
- `sh_ctrl`, `sh_ien` and `in_sel` are combinational from state and the same-cycle handshake, so the shift happens on the accepting edge.
- `in_ready`, `issue_valid`, `out_valid`, `busy` and `done` are decoded from the state register. All other state is registered.
- Latency:
  - `start` to `in_ready`: 1 cycle.
  - Last load accept to `issue_valid`: 1 cycle.
  - `upd_valid` to next `issue_valid`: 1 cycle.
  - Last drain accept to `done`: 1 cycle.
  - `done` to IDLE: 1 cycle.
- `start` outside IDLE is ignored.
- `upd_valid` in any state other than WAIT causes no shift and sets `err`.
- `upd_valid` in the same cycle as `issue_ready` (still in ISSUE) is an error: it sets `err` and is dropped.
- `in_valid` outside LOAD and `out_ready` outside DRAIN are ignored.
- Minimum solve length with all handshakes tied high and `upd_valid` returned 1 cycle after issue: 1 + 16 + 32·N + 16 + 1 cycles.

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles mid-LOAD after 7 words -> all outputs 0, state IDLE; the next `start` needs a full 16 loads.
- **Load with gaps:** `start`, then 16 words with `in_valid` toggling every cycle -> exactly 16 cycles with `sh_ctrl=001`/`sh_ien=1`/`in_sel=0`, then `issue_valid` 1 cycle after the 16th accept.
- **Two iterations:** `iter_num=2`, `issue_ready=1`, `upd_valid` returned 3 cycles after each issue -> `row_idx` runs 0..15 twice, `iter_cnt` reaches 1 then 2, 32 write-back shifts, then `out_valid`.
- **Drain backpressure:** in DRAIN, `out_ready` high on alternate cycles -> 16 rotate shifts (`sh_ien=0`), no shift on low cycles, `done` pulses once, then `busy=0`.
- **Protocol errors:** `upd_valid` in ISSUE and a `start` during WAIT -> `err=1`, no shift, no restart; the next accepted `start` clears `err`.
- **Zero iterations:** `iter_num=0` -> behaves as 1: 16 issues, then DRAIN.
